// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load/store, drives a single-cycle data_memory access,
// then aligns/extends load data and returns one response. Optional LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_base,
    input  logic [XLEN-1:0]   req_offset,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_exc,
    output logic [3:0]        resp_exc_cause,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [2:0]        mem_load_type,
    output logic [2:0]        mem_store_type,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic              op_store_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [4:0]        rd_reg;
    logic              skip_reg;
    logic              hold_reg;
    logic [XLEN-1:0]   data_hold_reg;

    logic [ADDR_W-1:0] ea;
    logic              accept;
    logic              funct3_ok;
    logic              skip_req;
    logic [XLEN-1:0]   load_data;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [7:0]        rbyte [4];
    logic [15:0]       rhalf [2];

    assign ea     = ADDR_W'(req_base + req_offset);
    assign accept = req_valid && (state_reg == IDLE);

    always_comb begin
        funct3_ok = 1'b0;
        if (req_is_store) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
                default:                funct3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
                default:                                funct3_ok = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic       misalign;
    logic       exc_reg;
    logic [3:0] cause_reg;

    // funct3[1:0] encodes access size for both loads and stores
    assign misalign = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    assign skip_req = !funct3_ok || misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_reg   <= 1'b0;
            cause_reg <= 4'd0;
        end else if (accept) begin
            exc_reg   <= skip_req;
            if (!funct3_ok)
                cause_reg <= 4'd2;
            else if (misalign)
                cause_reg <= req_is_store ? 4'd6 : 4'd4;
            else
                cause_reg <= 4'd0;
        end
    end

    assign resp_exc       = (state_reg == RESP) && exc_reg;
    assign resp_exc_cause = (state_reg == RESP) ? cause_reg : 4'd0;
`else
    assign skip_req       = !funct3_ok;
    assign resp_exc       = 1'b0;
    assign resp_exc_cause = 4'd0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; faulting or invalid requests bypass the memory access
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = skip_req ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state_reg)
            IDLE:   req_ready = 1'b1;
            ACCESS: begin
                mem_read_en  = !op_store_reg;
                mem_write_en = op_store_reg;
            end
            RESP:   resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch and response hold
    always_ff @(posedge clk) begin
        if (rst) begin
            op_store_reg  <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_reg        <= 5'd0;
            skip_reg      <= 1'b0;
            hold_reg      <= 1'b0;
            data_hold_reg <= '0;
        end else if (accept) begin
            op_store_reg <= req_is_store;
            funct3_reg   <= req_funct3;
            addr_reg     <= ea;
            wdata_reg    <= req_wdata;
            rd_reg       <= req_rd;
            skip_reg     <= skip_req;
            hold_reg     <= 1'b0;
        end else if (state_reg == RESP) begin
            if (resp_ready) begin
                hold_reg <= 1'b0;
            end else if (!hold_reg) begin
                // mem_rdata is only guaranteed on the first RESP cycle
                hold_reg      <= 1'b1;
                data_hold_reg <= resp_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign rbyte[gi] = mem_rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign rhalf[gi] = mem_rdata[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        sel_byte  = rbyte[addr_reg[1:0]];
        sel_half  = rhalf[addr_reg[1]];
        load_data = '0;
        case (funct3_reg)
            3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
            3'b010:  load_data = mem_rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        resp_data = '0;
        if (state_reg == RESP) begin
            if (hold_reg)
                resp_data = data_hold_reg;
            else if (!op_store_reg && !skip_reg)
                resp_data = load_data;
        end
    end

    assign resp_rd        = ((state_reg == RESP) && !op_store_reg) ? rd_reg : 5'd0;
    assign mem_load_type  = 3'b010;
    assign mem_store_type = funct3_reg;
    assign mem_address    = addr_reg;
    assign mem_wdata      = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, hand sequences and random ops checked
// against a byte-array reference model; includes a small synchronous data_memory.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_exc;
    logic [3:0]  resp_exc_cause;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  mem_load_type;
    logic [2:0]  mem_store_type;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_exc(resp_exc), .resp_exc_cause(resp_exc_cause),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // data_memory stand-in: word array, synchronous read, byte-lane writes
    logic [31:0] dmem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;
    int rd_cnt = 0, wr_cnt = 0, ltype_bad = 0;
    logic [31:0] last_addr, last_wdata;
    logic [2:0]  last_stype;

    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_val;
        if (mem_write_en) begin
            case (mem_store_type)
                3'b000: dmem[mem_address[9:2]][8*mem_address[1:0] +: 8] <= mem_wdata[7:0];
                3'b001: dmem[mem_address[9:2]][16*mem_address[1] +: 16] <= mem_wdata[15:0];
                3'b010: dmem[mem_address[9:2]] <= mem_wdata;
                default: ;
            endcase
            wr_cnt     <= wr_cnt + 1;
            last_addr  <= mem_address;
            last_wdata <= mem_wdata;
            last_stype <= mem_store_type;
        end
        if (mem_read_en) begin
            mem_rdata <= dmem[mem_address[9:2]];
            rd_cnt    <= rd_cnt + 1;
            last_addr <= mem_address;
            if (mem_load_type != 3'b010) ltype_bad <= ltype_bad + 1;
        end
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory and the RV32I width/sign rules
    typedef struct {
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
        int          lat;
        int          rds;
        int          wrs;
    } res_t;

    logic [7:0] ref_mem [0:1023];

    function automatic res_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] ea, input logic [31:0] wd);
        res_t r;
        bit ok;
        logic [31:0] size, a, val;
        r = '{data: 32'd0, exc: 1'b0, cause: 4'd0, lat: 2, rds: 0, wrs: 0};
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok) begin
            r.lat = 1; r.exc = TRAP; r.cause = TRAP ? 4'd2 : 4'd0;
            return r;
        end
        size = 32'd1 << f3[1:0];
        if (TRAP && ((ea & (size - 1)) != 0)) begin
            r.lat = 1; r.exc = 1'b1; r.cause = st ? 4'd6 : 4'd4;
            return r;
        end
        a = ea & ~(size - 1);
        if (st) begin
            r.wrs = 1;
            for (int k = 0; k < int'(size); k++) ref_mem[a[9:0] + 10'(k)] = wd[8*k +: 8];
        end else begin
            r.rds = 1;
            val = 0;
            for (int k = 0; k < int'(size); k++) val = val | (32'(ref_mem[a[9:0] + 10'(k)]) << (8*k));
            if (!f3[2] && size < 4 && val[8*size - 1]) val = val | (32'hFFFFFFFF << (8*size));
            r.data = val;
        end
        return r;
    endfunction

    task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                         input logic [4:0] rd, input int stall, input res_t e);
        int n, r0, w0;
        bit got;
        logic [31:0] d;
        logic [4:0]  r;
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        r0 = rd_cnt; w0 = wr_cnt;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; got = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1;
        end
        check({tag, ".latency"}, got ? 32'(n) : 32'hFFFFFFFF, 32'(e.lat));
        if (got) begin
            check({tag, ".data"}, resp_data, e.data);
            check({tag, ".exc"}, 32'(resp_exc), 32'(e.exc));
            check({tag, ".cause"}, 32'(resp_exc_cause), 32'(e.cause));
            if (st) check({tag, ".rd"}, 32'(resp_rd), 32'd0);
            else if (e.lat == 2) check({tag, ".rd"}, 32'(resp_rd), 32'(rd));
            d = resp_data; r = resp_rd;
            if (stall > 0) begin
                resp_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
                    check({tag, ".hold_data"}, resp_data, d);
                    check({tag, ".hold_rd"}, 32'(resp_rd), 32'(r));
                    check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
                end
                resp_ready = 1'b1;
            end
            @(negedge clk);
            check({tag, ".released"}, {31'd0, resp_valid}, 32'd0);
            check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        end
        check({tag, ".reads"}, 32'(rd_cnt - r0), 32'(e.rds));
        check({tag, ".writes"}, 32'(wr_cnt - w0), 32'(e.wrs));
        if (e.rds + e.wrs > 0) check({tag, ".addr"}, last_addr, base + off);
        if (e.wrs > 0) begin
            check({tag, ".wdata"}, last_wdata, wd);
            check({tag, ".stype"}, 32'(last_stype), 32'(f3));
        end
        $display("[TB] %s st=%0d f3=%0d ea=%h data=%h exc=%0d cause=%0d lat=%0d",
                 tag, st, f3, base + off, d, e.exc, e.cause, n);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          stall;
        res_t        e;
    } vec_t;

    vec_t vecs [15];

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_mem[{idx, 2'b00} + 10'(k)] = val[8*k +: 8];
    endtask

    initial begin
        res_t e, unused;
        bit seen;
        logic st;
        logic [2:0] f3;
        logic [31:0] ea, base, wd;
        int pick;

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; pl_en = 1'b0;
        pl_idx = 8'd0; pl_val = 32'd0;
        req_is_store = 1'b0; req_funct3 = 3'd0; req_base = 32'd0;
        req_offset = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        for (int i = 0; i < 256; i++) preload(8'(i), 32'd0);
        preload(8'd4, 32'h80FF7F01);
        preload(8'd1, 32'h12345678);

        @(negedge clk);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.resp_data", resp_data, 32'd0);
        check("reset.resp_rd", 32'(resp_rd), 32'd0);
        check("reset.resp_exc", 32'(resp_exc), 32'd0);
        check("reset.cause", 32'(resp_exc_cause), 32'd0);
        check("reset.enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        check("reset.mem_address", mem_address, 32'd0);
        check("reset.mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        vecs[0]  = '{1'b0, 3'd0, 32'h10, 32'h3, 32'h0, 5'd1, 0, '{32'hFFFFFF80, 1'b0, 4'd0, 2, 1, 0}};
        vecs[1]  = '{1'b0, 3'd4, 32'h13, 32'h0, 32'h0, 5'd2, 0, '{32'h00000080, 1'b0, 4'd0, 2, 1, 0}};
        vecs[2]  = '{1'b0, 3'd1, 32'h20, 32'hFFFFFFF2, 32'h0, 5'd3, 0, '{32'hFFFF80FF, 1'b0, 4'd0, 2, 1, 0}};
        vecs[3]  = '{1'b0, 3'd5, 32'h12, 32'h0, 32'h0, 5'd4, 0, '{32'h000080FF, 1'b0, 4'd0, 2, 1, 0}};
        vecs[4]  = '{1'b1, 3'd2, 32'h20, 32'h0, 32'hDEADBEEF, 5'd5, 0, '{32'h0, 1'b0, 4'd0, 2, 0, 1}};
        vecs[5]  = '{1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 5'd6, 0, '{32'hDEADBEEF, 1'b0, 4'd0, 2, 1, 0}};
        vecs[6]  = '{1'b1, 3'd0, 32'h21, 32'h0, 32'h1234565A, 5'd7, 0, '{32'h0, 1'b0, 4'd0, 2, 0, 1}};
        vecs[7]  = '{1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 5'd8, 3, '{32'hDEAD5AEF, 1'b0, 4'd0, 2, 1, 0}};
        vecs[8]  = '{1'b0, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd9, 0, '{32'h12345678, 1'b0, 4'd0, 2, 1, 0}};
        vecs[9]  = TRAP ? '{1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 5'd10, 0, '{32'h0, 1'b1, 4'd4, 1, 0, 0}}
                        : '{1'b0, 3'd2, 32'h22, 32'h0, 32'h0, 5'd10, 0, '{32'hDEAD5AEF, 1'b0, 4'd0, 2, 1, 0}};
        vecs[10] = TRAP ? '{1'b1, 3'd1, 32'h21, 32'h0, 32'hAAAA1234, 5'd11, 0, '{32'h0, 1'b1, 4'd6, 1, 0, 0}}
                        : '{1'b1, 3'd1, 32'h21, 32'h0, 32'hAAAA1234, 5'd11, 0, '{32'h0, 1'b0, 4'd0, 2, 0, 1}};
        vecs[11] = '{1'b0, 3'd2, 32'h20, 32'h0, 32'h0, 5'd12, 0,
                     '{TRAP ? 32'hDEAD5AEF : 32'hDEAD1234, 1'b0, 4'd0, 2, 1, 0}};
        vecs[12] = '{1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 5'd13, 0, '{32'h0, TRAP, TRAP ? 4'd2 : 4'd0, 1, 0, 0}};
        vecs[13] = '{1'b1, 3'd5, 32'h20, 32'h0, 32'h0, 5'd14, 1, '{32'h0, TRAP, TRAP ? 4'd2 : 4'd0, 1, 0, 0}};
        vecs[14] = '{1'b0, 3'd4, 32'h10, 32'h0, 32'h0, 5'd15, 1, '{32'h00000001, 1'b0, 4'd0, 2, 1, 0}};

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].base, vecs[i].off,
                  vecs[i].wd, vecs[i].rd, vecs[i].stall, vecs[i].e);
            unused = model(vecs[i].st, vecs[i].f3, vecs[i].base + vecs[i].off, vecs[i].wd);
        end

        // Reset while a store is in ACCESS: the write lands, the response is dropped
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_base = 32'h30; req_offset = 32'h0; req_wdata = 32'h11111111; req_rd = 5'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstacc.wen", 32'(mem_write_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstacc.req_ready", 32'(req_ready), 32'd1);
        check("rstacc.resp_valid", 32'(resp_valid), 32'd0);
        check("rstacc.wen_drop", 32'(mem_write_en), 32'd0);
        check("rstacc.mem", dmem[12], 32'h11111111);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        check("rstacc.no_resp", 32'(seen), 32'd0);
        $display("[TB] rstacc SW 11111111 @30 interrupted by reset");
        unused = model(1'b1, 3'd2, 32'h30, 32'h11111111);
        e = model(1'b0, 3'd2, 32'h30, 32'h0);
        do_op("rstacc.lw", 1'b0, 3'd2, 32'h30, 32'h0, 32'h0, 5'd3, 0, e);

        for (int i = 0; i < 60; i++) begin
            st   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 11));
            f3   = (pick < 8) ? 3'(pick) : (st ? 3'd2 : 3'd0);
            ea   = 32'($urandom_range(32'h40, 32'h3FF));
            base = $urandom;
            wd   = $urandom;
            e = model(st, f3, ea, wd);
            do_op($sformatf("rnd%0d", i), st, f3, base, ea - base, wd, 5'($urandom_range(1, 31)),
                  int'($urandom_range(0, 2)), e);
        end

        check("load_type_word", 32'(ltype_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
